vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator that drives the sprite renderers and the VGA pins. It divides the system clock into a pixel tick and runs horizontal/vertical counters (`hc`, `vc`) that every sprite block uses to compute its ROM address. It decodes `blank`, `hsync` and `vsync`, and emits line/frame strobes. It also delays the sync/blank outputs by the sprite-ROM read latency, so the pins line up with `mem_value`-derived RGB.

## Interface
- `CLK_DIV`, default 4: system clocks per pixel; legal range is 1 or more (100 MHz to 25 MHz).
- `H_VISIBLE`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal timing, giving `H_TOTAL` = 800.
- `V_VISIBLE`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical timing, giving `V_TOTAL` = 525.
- `PIPE`, default 1: pixel ticks of delay on `*_d` outputs (sprite ROM latency); legal range 0–3.
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `pix_tick`, out, 1: one-`clk` strobe; counters advance on it.
- `hc`, out, 11: horizontal pixel count, 0 to `H_TOTAL`-1.
- `vc`, out, 11: line count, 0 to `V_TOTAL`-1.
- `blank`, out, 1: high outside the visible area; aligned with `hc`/`vc`.
- `line_start`, out, 1: one-`clk` pulse when `hc` becomes 0.
- `frame_start`, out, 1: one-`clk` pulse when (`hc`,`vc`) becomes (0,0).
- `hsync_d`, out, 1: active-low hsync, delayed `PIPE` ticks.
- `vsync_d`, out, 1: active-low vsync, delayed `PIPE` ticks.
- `blank_d`, out, 1: `blank`, delayed `PIPE` ticks.

## Operation
- **Divider:** `div_cnt` counts 0 to `CLK_DIV`-1 and wraps.
  - `pix_tick` is registered and is high for the one `clk` after `div_cnt` reaches `CLK_DIV`-1.
  - When `CLK_DIV`=1, `pix_tick` is constantly 1 after the first clock following reset.
- **Counters:** updated only on clocks where `pix_tick`=1.
  - `hc` increments. At `H_TOTAL`-1, `hc` goes to 0 and `vc` increments.
  - When `vc` is at `V_TOTAL`-1 and `hc` wraps, `vc` goes to 0.
  - Counter arithmetic is 11-bit unsigned. Values at or above the total never occur.
- **Decode:** registered, computed from next-state counters so it changes in the same clock as `hc`/`vc`.
  - `blank` = (`hc` >= `H_VISIBLE`) or (`vc` >= `V_VISIBLE`).
  - hsync is low for `hc` in [`H_VISIBLE`+`H_FP`, `H_VISIBLE`+`H_FP`+`H_SYNC`), i.e. [656, 752).
  - vsync is low for `vc` in [490, 492).
- **Strobes:**
  - `line_start` is high for the single `clk` in which `hc` has just become 0.
  - `frame_start` is high for the single `clk` in which both `hc` and `vc` have just become 0.
  - Neither strobe asserts out of reset; the first pulse occurs at the first wrap.
- **Delay line:** `{hsync, vsync, blank}` pass through a `PIPE`-stage shift register that advances only on `pix_tick`.
  - `PIPE`=0 is a direct pass-through.
  - Consumers sample RGB from ROM `PIPE` ticks after presenting `hc`/`vc`, so the `*_d` outputs align with that RGB.

## Timing
- **Reset values** while `rst_n`=0:
  - `div_cnt`=0, `pix_tick`=0, `hc`=0, `vc`=0.
  - `blank`=0, since (0,0) is visible.
  - `line_start`=0, `frame_start`=0.
  - `hsync_d`=1, `vsync_d`=1, and all delay stages are 1.
  - `blank_d`=0.
- **Reset mid-frame:** asynchronous assertion clears every register immediately.
  - After deassertion, counting resumes from (0,0), with the first `pix_tick` `CLK_DIV` clocks later.
  - No partial-line strobe is produced.
- **Pixel period:** `CLK_DIV` clocks. Line is `H_TOTAL`·`CLK_DIV` clocks (3200 at defaults). Frame is `H_TOTAL`·`V_TOTAL`·`CLK_DIV` clocks (1,680,000 at defaults).
- **Decode latency:** `blank`, `line_start` and `frame_start` change in the same `clk` edge as the counter they describe; there is no skew against `hc`/`vc`.
- **`*_d` outputs:** lag the undelayed decode by exactly `PIPE` pixel ticks (`PIPE`·`CLK_DIV` clocks).
- **Simultaneous wrap:** at (`H_TOTAL`-1, `V_TOTAL`-1), one tick produces (0,0), and `line_start` and `frame_start` pulse together.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 clocks with random prior state. All outputs must equal their reset values. Release; the first `pix_tick` must occur on clock 4 and `hc` must reach 1 on that tick.
- **Horizontal line:** run one line at defaults.
  - `hsync_d` (`PIPE`=1) must go low exactly 1 tick after `hc`=656 and stay low for 96 ticks.
  - `blank` must rise at `hc`=640.
  - `line_start` pulses must be 3200 clocks apart.
- **Full frame:**
  - `frame_start` pulses must be 1,680,000 clocks apart.
  - vsync must be low for exactly 2 lines starting at `vc`=490.
  - `blank` must be high for all of lines 480–524.
- **Corner wrap:** force run to `hc`=799, `vc`=524 and apply one tick. Expect `hc`=0, `vc`=0, `line_start`=1, `frame_start`=1 in the same clock, and `blank`=0.
- **Mid-operation reset:** pulse `rst_n` low for 1 clock at `hc`=300, `vc`=200. Outputs must clear asynchronously, and counting must restart at (0,0) with no spurious `frame_start`.
- **`CLK_DIV`=1, `PIPE`=0:**
  - `pix_tick` must be high continuously after the first clock, and `hc` must advance every clock.
  - `hsync_d` must coincide with the undelayed decode, i.e. it is low at `hc`=656.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Pixel-timing generator: clock divider, hc/vc raster counters, blank/sync decode,
// line/frame strobes and a pixel-tick delay line aligning sync/blank with sprite-ROM RGB.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIPE      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_tick,
  output logic [10:0] hc,
  output logic [10:0] vc,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        blank_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0]   V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0]   HS_LO    = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0]   HS_HI    = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_LO    = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0]   VS_HI    = 11'(V_VISIBLE + V_FP + V_SYNC);

  function automatic logic in_range(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [DW-1:0] div_cnt_r, div_nx_s;
  logic          tick_s;
  logic          pix_tick_r;
  logic [10:0]   hc_r, vc_r, hc_nx_s, vc_nx_s;
  logic          blank_r, hsync_r, vsync_r;
  logic          line_start_r, frame_start_r;
  logic [2:0]    dly_s;

  // Divider and raster next-state; decode is taken from these so it never skews hc/vc.
  always_comb begin
    tick_s   = (div_cnt_r == DIV_LAST);
    div_nx_s = div_cnt_r;
    hc_nx_s  = hc_r;
    vc_nx_s  = vc_r;
    if (tick_s) begin
      div_nx_s = '0;
    end else begin
      div_nx_s = div_cnt_r + DW'(1);
    end
    if (hc_r == H_LAST) begin
      hc_nx_s = 11'd0;
      if (vc_r == V_LAST) begin
        vc_nx_s = 11'd0;
      end else begin
        vc_nx_s = vc_r + 11'd1;
      end
    end else begin
      hc_nx_s = hc_r + 11'd1;
      vc_nx_s = vc_r;
    end
  end

  // Divider, counters, decode and strobes; everything moves on the same tick edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r     <= '0;
      pix_tick_r    <= 1'b0;
      hc_r          <= 11'd0;
      vc_r          <= 11'd0;
      blank_r       <= 1'b0;
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div_cnt_r  <= div_nx_s;
      pix_tick_r <= tick_s;
      if (tick_s) begin
        hc_r          <= hc_nx_s;
        vc_r          <= vc_nx_s;
        blank_r       <= (hc_nx_s >= H_VIS) || (vc_nx_s >= V_VIS);
        hsync_r       <= ~in_range(hc_nx_s, HS_LO, HS_HI);
        vsync_r       <= ~in_range(vc_nx_s, VS_LO, VS_HI);
        line_start_r  <= (hc_nx_s == 11'd0);
        frame_start_r <= (hc_nx_s == 11'd0) && (vc_nx_s == 11'd0);
      end else begin
        line_start_r  <= 1'b0;
        frame_start_r <= 1'b0;
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_nopipe
      assign dly_s = {hsync_r, vsync_r, blank_r};
    end else begin : g_pipe
      logic [2:0] stage_r [PIPE];
      // Tick-paced shift register matching the sprite-ROM read latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE; i++) stage_r[i] <= 3'b110;
        end else if (tick_s) begin
          stage_r[0] <= {hsync_r, vsync_r, blank_r};
          for (int i = 1; i < PIPE; i++) stage_r[i] <= stage_r[i-1];
        end
      end
      assign dly_s = stage_r[PIPE-1];
    end
  endgenerate

  assign pix_tick    = pix_tick_r;
  assign hc          = hc_r;
  assign vc          = vc_r;
  assign blank       = blank_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign hsync_d     = dly_s[2];
  assign vsync_d     = dly_s[1];
  assign blank_d     = dly_s[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance, CLK_DIV=1/PIPE=0 instance, and a
// miniature-raster instance (16x12, CLK_DIV=2, PIPE=2) for frame and wrap behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic        d_tick, d_bl, d_ls, d_fs, d_hs, d_vs, d_bd;
  logic [10:0] d_hc, d_vc;
  logic        f_tick, f_bl, f_ls, f_fs, f_hs, f_vs, f_bd;
  logic [10:0] f_hc, f_vc;
  logic        s_tick, s_bl, s_ls, s_fs, s_hs, s_vs, s_bd;
  logic [10:0] s_hc, s_vc;

  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .pix_tick(d_tick), .hc(d_hc), .vc(d_vc), .blank(d_bl),
    .line_start(d_ls), .frame_start(d_fs), .hsync_d(d_hs), .vsync_d(d_vs), .blank_d(d_bd));

  vga_timing_gen #(.CLK_DIV(1), .PIPE(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .pix_tick(f_tick), .hc(f_hc), .vc(f_vc), .blank(f_bl),
    .line_start(f_ls), .frame_start(f_fs), .hsync_d(f_hs), .vsync_d(f_vs), .blank_d(f_bd));

  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .PIPE(2)) u_small (
    .clk(clk), .rst_n(rst_n), .pix_tick(s_tick), .hc(s_hc), .vc(s_vc), .blank(s_bl),
    .line_start(s_ls), .frame_start(s_fs), .hsync_d(s_hs), .vsync_d(s_vs), .blank_d(s_bd));

  task automatic check_def_reset(input string ph);
    check_eq({ph, "_pix_tick"}, d_tick, 0);
    check_eq({ph, "_hc"}, d_hc, 0);
    check_eq({ph, "_vc"}, d_vc, 0);
    check_eq({ph, "_blank"}, d_bl, 0);
    check_eq({ph, "_line_start"}, d_ls, 0);
    check_eq({ph, "_frame_start"}, d_fs, 0);
    check_eq({ph, "_hsync_d"}, d_hs, 1);
    check_eq({ph, "_vsync_d"}, d_vs, 1);
    check_eq({ph, "_blank_d"}, d_bd, 0);
  endtask

  initial begin
    int def_ls_t[2];
    int def_ls_cnt, def_fs_cnt, hs_low;
    int fast_bad;
    int sm_fs_t[2];
    int sm_fs_cnt, vs_low, bl_bad;
    logic [10:0] s_phc, s_pvc;
    int sm_ls_first, sm_fs_first;
    bit found;

    // Random prior state, then asynchronous reset in mid-cycle.
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat ($urandom_range(20, 60)) @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_def_reset("rst_async");
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_def_reset("rst_hold");
    check_eq("rst_small_vsync_d", s_vs, 1);
    rst_n = 1'b1;

    def_ls_t = '{-1, -1}; def_ls_cnt = 0; def_fs_cnt = 0; hs_low = 0;
    fast_bad = 0;
    sm_fs_t = '{-1, -1}; sm_fs_cnt = 0; vs_low = 0; bl_bad = 0;
    s_phc = 11'd0; s_pvc = 11'd0;

    for (int n = 1; n <= 7000; n++) begin
      @(posedge clk);
      @(negedge clk);
      // Default instance: first tick, line timing.
      if (n == 3) check_eq("first_tick_pre", d_tick, 0);
      if (n == 4) begin
        check_eq("first_tick", d_tick, 1);
        check_eq("first_tick_hc", d_hc, 1);
      end
      if (n == 5) check_eq("first_tick_post", d_tick, 0);
      if (d_tick && def_ls_cnt == 0) begin
        if (d_hc == 11'd656) check_eq("hsync_d_at656", d_hs, 1);
        if (d_hc == 11'd657) check_eq("hsync_d_at657", d_hs, 0);
        if (d_hc == 11'd752) check_eq("hsync_d_at752", d_hs, 0);
        if (d_hc == 11'd753) check_eq("hsync_d_at753", d_hs, 1);
        if (d_hc == 11'd639) check_eq("blank_at639", d_bl, 0);
        if (d_hc == 11'd640) check_eq("blank_at640", d_bl, 1);
        if (!d_hs) hs_low++;
      end
      if (d_ls) begin
        if (def_ls_cnt < 2) def_ls_t[def_ls_cnt] = n;
        if (def_ls_cnt == 0) check_eq("def_ls_hc", d_hc, 0);
        def_ls_cnt++;
      end
      if (d_fs) def_fs_cnt++;

      // CLK_DIV=1, PIPE=0 instance.
      if (n < 800) begin
        if (!f_tick || f_hc != 11'(n)) fast_bad++;
        if (f_hc == 11'd655) check_eq("fast_hsync_655", f_hs, 1);
        if (f_hc == 11'd656) check_eq("fast_hsync_656", f_hs, 0);
        if (f_hc == 11'd751) check_eq("fast_hsync_751", f_hs, 0);
        if (f_hc == 11'd752) check_eq("fast_hsync_752", f_hs, 1);
      end
      if (n == 800) check_eq("fast_ls_800", f_ls, 1);

      // Miniature raster: frame timing, vsync, blank, corner wrap.
      if (s_tick) begin
        if (s_bl !== ((s_hc >= 11'd8) || (s_vc >= 11'd6))) bl_bad++;
        if (sm_fs_cnt == 1 && !s_vs) vs_low++;
        if (s_vc == 11'd2 && s_hc == 11'd9) check_eq("small_blank_d_hc9", s_bd, 0);
        if (s_vc == 11'd2 && s_hc == 11'd10) check_eq("small_blank_d_hc10", s_bd, 1);
        if (s_fs && sm_fs_cnt == 0) begin
          check_eq("wrap_prev_hc", s_phc, 15);
          check_eq("wrap_prev_vc", s_pvc, 11);
          check_eq("wrap_hc", s_hc, 0);
          check_eq("wrap_vc", s_vc, 0);
          check_eq("wrap_line_start", s_ls, 1);
          check_eq("wrap_blank", s_bl, 0);
        end
        s_phc = s_hc;
        s_pvc = s_vc;
      end
      if (s_fs) begin
        if (sm_fs_cnt < 2) sm_fs_t[sm_fs_cnt] = n;
        sm_fs_cnt++;
      end
    end

    check_eq("hsync_low_ticks", hs_low, 96);
    check_eq("def_first_ls", def_ls_t[0], 3200);
    check_eq("def_ls_period", def_ls_t[1] - def_ls_t[0], 3200);
    check_eq("def_no_frame_start", def_fs_cnt, 0);
    check_eq("fast_tick_every_clk", fast_bad, 0);
    check_eq("small_first_fs", sm_fs_t[0], 384);
    check_eq("small_fs_period", sm_fs_t[1] - sm_fs_t[0], 384);
    check_eq("small_vsync_low_ticks", vs_low, 32);
    check_eq("small_blank_decode", bl_bad, 0);

    // Mid-operation reset on the miniature raster at (5,3).
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (s_tick && s_hc == 11'd5 && s_vc == 11'd3) found = 1'b1;
    end
    check_eq("midrst_reach", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_hc", s_hc, 0);
    check_eq("midrst_vc", s_vc, 0);
    check_eq("midrst_tick", s_tick, 0);
    check_eq("midrst_vsync_d", s_vs, 1);
    check_eq("midrst_def_hc", d_hc, 0);
    @(negedge clk) rst_n = 1'b1;

    sm_ls_first = -1; sm_fs_first = -1;
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 2) check_eq("midrst_restart_hc", s_hc, 1);
      if (s_ls && sm_ls_first < 0) sm_ls_first = n;
      if (s_fs && sm_fs_first < 0) sm_fs_first = n;
    end
    check_eq("midrst_first_ls", sm_ls_first, 32);
    check_eq("midrst_first_fs", sm_fs_first, 384);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
